// File: rtl/cmp_pkg.sv
// Shared types for the column filter predicate path: opcode encoding,
// cmd field positions and the column-tracking FSM states.
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_EQ    = 3'd0,
    OP_NE    = 3'd1,
    OP_LT    = 3'd2,
    OP_LE    = 3'd3,
    OP_GT    = 3'd4,
    OP_GE    = 3'd5,
    OP_TRUE  = 3'd6,
    OP_FALSE = 3'd7
  } cmp_op_e;

  localparam int CMD_UNSIGNED_BIT = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COL  = 1'b1
  } col_state_e;

endpackage

// File: rtl/cmp_lane.sv
// One combinational lane compare: match = en & (a op b), signed or unsigned.
module cmp_lane
  import cmp_pkg::*;
#(
  parameter int NUM_SIZE = 32
) (
  input  logic [NUM_SIZE-1:0] a,
  input  logic [NUM_SIZE-1:0] b,
  input  cmp_op_e             op,
  input  logic                is_unsigned,
  input  logic                en,
  output logic                match
);

  logic lt_s;
  logic eq_s;
  logic res_s;

  assign eq_s = (a == b);

  // Less-than under the selected number interpretation
  always_comb begin
    lt_s = 1'b0;
    if (is_unsigned) begin
      lt_s = (a < b);
    end else begin
      lt_s = ($signed(a) < $signed(b));
    end
  end

  // Opcode decode; disabled lanes never match, even under TRUE
  always_comb begin
    res_s = 1'b0;
    case (op)
      OP_EQ:    res_s = eq_s;
      OP_NE:    res_s = ~eq_s;
      OP_LT:    res_s = lt_s;
      OP_LE:    res_s = lt_s | eq_s;
      OP_GT:    res_s = ~(lt_s | eq_s);
      OP_GE:    res_s = ~lt_s;
      OP_TRUE:  res_s = 1'b1;
      OP_FALSE: res_s = 1'b0;
      default:  res_s = 1'b0;
    endcase
  end

  assign match = en & res_s;

endmodule

// File: rtl/cmp_filter_stream.sv
// Multi-lane streaming predicate unit: two-stage valid/ready pipeline producing
// a per-beat lane mask and a saturating per-column match count.
module cmp_filter_stream
  import cmp_pkg::*;
#(
  parameter int NUM_SIZE      = 32,
  parameter int LANES         = 4,
  parameter int CMD_SIZE_LOG2 = 3,
  parameter int CNT_W         = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [LANES*NUM_SIZE-1:0]   s_in1,
  input  logic [LANES*NUM_SIZE-1:0]   s_in2,
  input  logic [LANES-1:0]            s_lane_en,
  input  logic                        s_last,
  input  logic [(2**CMD_SIZE_LOG2)-1:0] cmd,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LANES-1:0]            m_mask,
  output logic                        m_last,
  output logic                        cnt_valid,
  output logic [CNT_W-1:0]            cnt
);

  localparam int PC_W = $clog2(LANES + 1);

  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [PC_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, acc} + (CNT_W + 1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  col_state_e               state_r;
  cmp_op_e                  op_lat_r;
  logic                     uns_lat_r;
  cmp_op_e                  eff_op_s;
  logic                     eff_uns_s;
  logic                     unused_cmd_s;

  logic                     v1_r;
  logic [LANES*NUM_SIZE-1:0] a1_r;
  logic [LANES*NUM_SIZE-1:0] b1_r;
  logic [LANES-1:0]         en1_r;
  logic                     last1_r;
  cmp_op_e                  op1_r;
  logic                     uns1_r;

  logic                     v2_r;
  logic [LANES-1:0]         mask_r;
  logic                     last2_r;
  logic [LANES-1:0]         mask_s;

  logic                     ready1_s;
  logic                     ready2_s;
  logic                     accept_s;
  logic                     xfer_s;

  logic [CNT_W-1:0]         acc_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     cnt_valid_r;

  assign ready2_s     = ~v2_r | m_ready;
  assign ready1_s     = ~v1_r | ready2_s;
  assign s_ready      = ~reset & ready1_s;
  assign accept_s     = s_valid & s_ready;
  assign xfer_s       = v2_r & m_ready;
  assign unused_cmd_s = ^cmd;

  // Live cmd applies only to the first beat of a column; later beats reuse the latch
  always_comb begin
    eff_op_s  = op_lat_r;
    eff_uns_s = uns_lat_r;
    if (state_r == ST_IDLE) begin
      eff_op_s  = cmp_op_e'(cmd[2:0]);
      eff_uns_s = cmd[CMD_UNSIGNED_BIT];
    end else begin
      eff_op_s  = op_lat_r;
      eff_uns_s = uns_lat_r;
    end
  end

  // Column FSM and cmd latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_lat_r  <= OP_EQ;
      uns_lat_r <= 1'b0;
    end else if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          op_lat_r  <= eff_op_s;
          uns_lat_r <= eff_uns_s;
          state_r   <= s_last ? ST_IDLE : ST_COL;
        end
        ST_COL:  state_r <= s_last ? ST_IDLE : ST_COL;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: operands, lane enables, last and effective cmd
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r    <= 1'b0;
      a1_r    <= '0;
      b1_r    <= '0;
      en1_r   <= '0;
      last1_r <= 1'b0;
      op1_r   <= OP_EQ;
      uns1_r  <= 1'b0;
    end else if (ready1_s) begin
      v1_r <= accept_s;
      if (accept_s) begin
        a1_r    <= s_in1;
        b1_r    <= s_in2;
        en1_r   <= s_lane_en;
        last1_r <= s_last;
        op1_r   <= eff_op_s;
        uns1_r  <= eff_uns_s;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cmp_lane #(.NUM_SIZE(NUM_SIZE)) u_lane (
      .a           (a1_r[i*NUM_SIZE +: NUM_SIZE]),
      .b           (b1_r[i*NUM_SIZE +: NUM_SIZE]),
      .op          (op1_r),
      .is_unsigned (uns1_r),
      .en          (en1_r[i]),
      .match       (mask_s[i])
    );
  end

  // Stage 2: registered mask/last, held while stalled downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_r    <= 1'b0;
      mask_r  <= '0;
      last2_r <= 1'b0;
    end else if (ready2_s) begin
      v2_r    <= v1_r;
      mask_r  <= mask_s;
      last2_r <= last1_r & v1_r;
    end
  end

  // Match accumulation on output transfer; column total published on m_last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      cnt_valid_r <= 1'b0;
    end else if (xfer_s) begin
      if (last2_r) begin
        cnt_r       <= sat_add(acc_r, popcount(mask_r));
        acc_r       <= '0;
        cnt_valid_r <= 1'b1;
      end else begin
        acc_r       <= sat_add(acc_r, popcount(mask_r));
        cnt_valid_r <= 1'b0;
      end
    end else begin
      cnt_valid_r <= 1'b0;
    end
  end

  assign m_valid   = v2_r;
  assign m_mask    = mask_r;
  assign m_last    = last2_r;
  assign cnt_valid = cnt_valid_r;
  assign cnt       = cnt_r;

endmodule

// File: tb/tb_cmp_filter_stream.sv
// Randomized bench for cmp_filter_stream against an integer-arithmetic
// reference model with an expected-beat queue and column count tracking.
module tb_cmp_filter_stream;

  localparam int NS      = 8;
  localparam int LN      = 4;
  localparam int CL2     = 3;
  localparam int CW      = 4;
  localparam int CMDW    = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 s_valid;
  logic                 s_ready;
  logic [LN*NS-1:0]     s_in1;
  logic [LN*NS-1:0]     s_in2;
  logic [LN-1:0]        s_lane_en;
  logic                 s_last;
  logic [CMDW-1:0]      cmd;
  logic                 m_valid;
  logic                 m_ready;
  logic [LN-1:0]        m_mask;
  logic                 m_last;
  logic                 cnt_valid;
  logic [CW-1:0]        cnt;

  cmp_filter_stream #(
    .NUM_SIZE(NS), .LANES(LN), .CMD_SIZE_LOG2(CL2), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_in1(s_in1), .s_in2(s_in2), .s_lane_en(s_lane_en), .s_last(s_last),
    .cmd(cmd), .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask),
    .m_last(m_last), .cnt_valid(cnt_valid), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LN*NS-1:0] a;
    logic [LN*NS-1:0] b;
    logic [LN-1:0]    en;
    logic             last;
    logic [CMDW-1:0]  cmd;
  } beat_t;

  beat_t          tx_q[$];
  logic [LN:0]    exp_q[$];
  beat_t          cur;
  int             n_chk = 0;
  int             n_pass = 0;
  int             n_acc = 0;
  int             in_pct = 100;
  int             rdy_pct = 100;
  bit             in_col = 1'b0;
  logic [3:0]     lat_cmd = 4'd0;
  int             acc_m = 0;
  int             cnt_hold = 0;
  bit             held_v = 1'b0;
  logic [LN:0]    held_out = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic bit lane_res(input logic [3:0] c, input logic [NS-1:0] a, input logic [NS-1:0] b);
    longint x;
    longint y;
    if (c[3]) begin
      x = longint'(a);
      y = longint'(b);
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end
    case (c[2:0])
      3'd0:    return x == y;
      3'd1:    return x != y;
      3'd2:    return x < y;
      3'd3:    return x <= y;
      3'd4:    return x > y;
      3'd5:    return x >= y;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_accept(input beat_t bt);
    logic [LN-1:0] m;
    if (!in_col) lat_cmd = bt.cmd[3:0];
    in_col = !bt.last;
    for (int i = 0; i < LN; i++)
      m[i] = bt.en[i] & lane_res(lat_cmd, bt.a[i*NS +: NS], bt.b[i*NS +: NS]);
    exp_q.push_back({bt.last, m});
  endtask

  task automatic model_reset();
    tx_q.delete();
    exp_q.delete();
    in_col   = 1'b0;
    acc_m    = 0;
    cnt_hold = 0;
    held_v   = 1'b0;
  endtask

  task automatic push(input logic [LN*NS-1:0] a, input logic [LN*NS-1:0] b,
                      input logic [LN-1:0] en, input logic last, input logic [CMDW-1:0] c);
    beat_t bt;
    bt.a = a; bt.b = b; bt.en = en; bt.last = last; bt.cmd = c;
    tx_q.push_back(bt);
  endtask

  task automatic present();
    if (tx_q.size() > 0 && $urandom_range(99) < in_pct) begin
      cur       = tx_q.pop_front();
      s_valid   = 1'b1;
      s_in1     = cur.a;
      s_in2     = cur.b;
      s_lane_en = cur.en;
      s_last    = cur.last;
      cmd       = cur.cmd;
    end else begin
      s_valid   = 1'b0;
      cmd       = CMDW'($urandom);
    end
  endtask

  task automatic step();
    bit          acc_e;
    bit          xf;
    bit          pend;
    logic [LN:0] e;
    pend = 1'b0;
    @(negedge clk);
    if (held_v) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_out", 32'({m_last, m_mask}), 32'(held_out));
    end
    held_v   = m_valid && !m_ready;
    held_out = {m_last, m_mask};
    acc_e = s_valid && s_ready;
    xf    = m_valid && m_ready;
    if (xf) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("mask", 32'(m_mask), 32'(e[LN-1:0]));
        chk("last", 32'(m_last), 32'(e[LN]));
        acc_m += $countones(e[LN-1:0]);
        if (e[LN]) begin
          pend     = 1'b1;
          cnt_hold = (acc_m > CNT_MAX) ? CNT_MAX : acc_m;
          acc_m    = 0;
        end
      end
    end
    if (acc_e) begin
      model_accept(cur);
      n_acc++;
    end
    @(posedge clk);
    #1;
    chk("cnt_valid", 32'(cnt_valid), 32'(pend));
    chk("cnt", 32'(cnt), 32'(cnt_hold));
    if (acc_e || !s_valid) present();
    m_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0 || s_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", 32'(tx_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [LN*NS-1:0] va;
    logic [LN*NS-1:0] vb;
    logic [LN*NS-1:0] a;
    logic [LN*NS-1:0] b;
    logic [LN-1:0]    en;

    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; cmd = '0;
    s_in1 = '0; s_in2 = '0; s_lane_en = '0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_mask", 32'(m_mask), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_cnt_valid", 32'(cnt_valid), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    reset = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // A={-1,5,127,-128}, B={0,5,-1,-127}; signed LT then unsigned LT
    va = {8'h80, 8'h7F, 8'h05, 8'hFF};
    vb = {8'h81, 8'hFF, 8'h05, 8'h00};
    rdy_pct = 100; in_pct = 100;
    push(va, vb, 4'hF, 1'b1, 8'h02);
    present();
    step();
    chk("lat_cyc1", 32'(m_valid), 32'd0);
    step();
    chk("lat_cyc2", 32'(m_valid), 32'd1);
    drain(50);
    push(va, vb, 4'hF, 1'b1, 8'h0A);
    drain(50);

    // 3-beat TRUE column; live cmd switches to FALSE after the first beat
    push(va, vb, 4'hF, 1'b0, 8'h06);
    push(va, vb, 4'hF, 1'b0, 8'h07);
    push(va, vb, 4'h3, 1'b1, 8'h07);
    // back-to-back single-beat EQ/NE on equal operands
    push(32'h07070707, 32'h07070707, 4'hF, 1'b1, 8'h00);
    push(32'h07070707, 32'h07070707, 4'hF, 1'b1, 8'h01);
    // 5 full TRUE beats: 20 matches saturates a 4-bit count
    for (int k = 0; k < 5; k++) push(va, vb, 4'hF, k == 4, 8'h06);
    drain(100);

    // backpressure: 4 beats offered with m_ready low for 5 cycles
    m_ready = 1'b0; rdy_pct = 0; n_acc = 0;
    for (int k = 0; k < 4; k++)
      push($urandom, $urandom, 4'hF, k == 3, CMDW'($urandom));
    present();
    repeat (5) step();
    chk("bp_accepts", 32'(n_acc), 32'd2);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    rdy_pct = 100;
    drain(100);

    // randomized columns with random gaps and backpressure
    in_pct = 80; rdy_pct = 70;
    for (int c = 0; c < 60; c++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < LN; i++)
          if ($urandom_range(3) == 0) b[i*NS +: NS] = a[i*NS +: NS];
        en = ($urandom_range(3) == 0) ? LN'($urandom) : 4'hF;
        push(a, b, en, k == len - 1, CMDW'($urandom));
      end
    end
    drain(5000);

    // reset mid-column after two accepted beats
    in_pct = 100; rdy_pct = 100; n_acc = 0;
    push(va, vb, 4'hF, 1'b0, 8'h06);
    push(va, vb, 4'hF, 1'b0, 8'h06);
    n = 0;
    while (n_acc < 2 && n < 50) begin
      step();
      n++;
    end
    chk("rst_mid_accepts", 32'(n_acc), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
    chk("rst_mid_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mid_m_mask", 32'(m_mask), 32'd0);
    chk("rst_mid_cnt", 32'(cnt), 32'd0);
    model_reset();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_cnt_valid", 32'(cnt_valid), 32'd0);
    reset = 1'b0;
    push(va, vb, 4'hF, 1'b1, 8'h06);
    drain(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
